arbiter_rr: RTL and testbench
=============================

# arbiter_rr

Round-robin request/grant arbiter: the design-under-test end of the arbiter interface whose testbench drives `request` and checks `grant`. It registers a one-hot grant to one of N requesters. A grant is held while its owner keeps requesting. A bounded hold limit forces rotation when other requesters are waiting. It sits between N bus masters and a shared resource, and is exercised directly through the arbiter interface.

## Interface
- `N`, default 2: number of requesters; legal range N >= 2.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is pending; 0 disables preemption.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `request`  in  N  request vector; bit i set means requester i wants the resource.
- `grant`  out  N  registered grant; one-hot or all-zero.
- `preempt`  out  1  one-cycle pulse, registered; high in the cycle a grant was moved away from a still-requesting owner.

## Operation
- State: FSM {IDLE, GRANT}, owner index `g`, round-robin pointer `ptr` (0..N-1), hold counter `hold_cnt` (width clog2(MAX_HOLD+1), minimum 1).
- Reset values: `grant`=0, `preempt`=0, state IDLE, `ptr`=0, `hold_cnt`=0. Reset asserted mid-grant clears `grant` immediately, without waiting for a clock edge.
- Selection: "next requester from p" is the first set bit of `request` scanning p, p+1, … N-1, 0, … p-1 (mod N).
- IDLE:
  - request==0: stay IDLE, `grant`=0.
  - Otherwise: grant the next requester from `ptr`, enter GRANT, set `hold_cnt`=1, set `ptr`=winner+1 mod N.
- GRANT, with owner g:
  - request[g]=0: re-arbitrate at the same edge with the next requester from g+1, so handoff has zero idle cycles. If there is none, `grant`<=0 and return to IDLE.
  - request[g]=1, another bit set, MAX_HOLD!=0 and `hold_cnt`==MAX_HOLD: grant the next requester from g+1, set `preempt`<=1, `hold_cnt`<=1, `ptr`<=new owner+1.
  - request[g]=1 otherwise: keep the grant. `hold_cnt` increments, saturating at MAX_HOLD; with MAX_HOLD=0 it saturates at its maximum value.
- `preempt` is 0 in every cycle not caused by the preemption rule.
- `grant` never has more than one bit set. `grant` is never given to a requester whose bit was 0 at the sampling edge.
- A requester that is sampled waiting is granted within (N-1)·MAX_HOLD+1 cycles, provided MAX_HOLD!=0.

## Timing
- `request` is sampled at the rising edge of `clk`. `grant` and `preempt` change only at that edge (or on `rst`).
- Latency is one edge. If `request` is driven nonblocking at edge k, it is sampled at edge k+1, and `grant` is stable for the sampling at edge k+2. This is the 2-edge check used by the interface testbench.
- Deasserting an owner's request removes or transfers `grant` at the next edge.
- Simultaneous deassertion by the owner and hold expiry: the deassert rule wins, and `preempt` stays 0.
- Release of `rst` is asynchronous to `clk`; the first arbitration happens at the first rising edge with `rst`=0.

## Test plan
- Reset, then `request`=01 driven at edge 1 → `grant`=00 through edge 1 and during reset; `grant`=01 when checked at edge 3; `preempt`=0.
- From IDLE after reset, `request`=11 → `grant`=01. Drop request[0] → `grant`=10 at the very next edge, with no 00 cycle in between.
- `request`=11 held for 20 cycles, N=2, MAX_HOLD=4 → `grant` shows 01 for 4 cycles, then 10 for 4 cycles, alternating. `preempt`=1 for exactly one cycle at each switch.
- `request`=10 held for 20 cycles → `grant`=10 continuously; `preempt` never asserts.
- Assert `rst` mid-cycle while `grant`=10 → `grant`=00 before the next edge. Release `rst` with `request`=10 → `grant`=10 after one edge.
- Sequence: owner 0 with `request`=01, then `request`=00, then `request`=11 → `grant` goes 01, then 00, then 10, because `ptr` advanced past the last owner.

Source files
------------

// File: rtl/arbiter_rr.sv
// Round-robin request/grant arbiter with a registered one-hot grant and a
// bounded hold limit that forces rotation while other requesters are waiting.
module arbiter_rr #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  output logic         preempt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  // With preemption disabled the counter simply saturates at all-ones.
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   g, g_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [N-1:0]    grant_n;
  logic            preempt_n;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (int'(v) == N - 1) ? '0 : IW'(int'(v) + 1);
  endfunction

  // Returns {found, index} of the first set bit scanning p, p+1, ... wrapping.
  function automatic logic [IW:0] next_from(input logic [N-1:0] req,
                                            input logic [IW-1:0] p);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(p) + k) % N;
      if (!res[IW] && req[idx]) begin
        res = {1'b1, IW'(idx)};
      end
    end
    return res;
  endfunction

  logic [IW:0] sel;
  logic        others;

  always_comb begin
    state_n   = state;
    g_n       = g;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    grant_n   = grant;
    preempt_n = 1'b0;
    sel       = '0;
    others    = (request & ~(N'(1) << g)) != '0;

    case (state)
      IDLE: begin
        grant_n = '0;
        if (request != '0) begin
          sel     = next_from(request, ptr);
          g_n     = sel[IW-1:0];
          grant_n = N'(1) << sel[IW-1:0];
          ptr_n   = inc_mod(sel[IW-1:0]);
          hold_n  = HW'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!request[g]) begin
          // Owner released: hand off at this same edge, no idle gap.
          sel = next_from(request, inc_mod(g));
          if (sel[IW]) begin
            g_n     = sel[IW-1:0];
            grant_n = N'(1) << sel[IW-1:0];
            ptr_n   = inc_mod(sel[IW-1:0]);
            hold_n  = HW'(1);
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (others && (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT)) begin
          sel       = next_from(request, inc_mod(g));
          g_n       = sel[IW-1:0];
          grant_n   = N'(1) << sel[IW-1:0];
          ptr_n     = inc_mod(sel[IW-1:0]);
          hold_n    = HW'(1);
          preempt_n = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      g        <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_n;
      g        <= g_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      preempt  <= preempt_n;
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed self-checking bench for arbiter_rr with N=2, MAX_HOLD=4.
module tb_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] request = 2'b00;
  logic [1:0] grant;
  logic       preempt;

  int checks = 0;
  int passes = 0;

  arbiter_rr #(.N(2), .MAX_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .grant(grant),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Drive request just after an edge, then let one rising edge sample it.
  task automatic applyStimulus(input logic [1:0] req);
    request = req;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    request = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset behaviour: grant stays 0 while rst is held, even with a request.
    request = 2'b01;
    @(posedge clk); #1;
    checkOutput("reset_grant", grant, 2'b00);
    checkOutput("reset_preempt", preempt, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_release_grant", grant, 2'b00);
    applyStimulus(2'b01);
    checkOutput("first_grant", grant, 2'b01);
    checkOutput("first_preempt", preempt, 1'b0);

    // Zero-gap handoff when the owner drops its request.
    resetDut();
    applyStimulus(2'b11);
    checkOutput("both_req_grant0", grant, 2'b01);
    applyStimulus(2'b10);
    checkOutput("handoff_grant1", grant, 2'b10);
    checkOutput("handoff_preempt", preempt, 1'b0);

    // Continuous contention: 4 cycles each, preempt pulse at every switch.
    resetDut();
    for (int t = 1; t <= 20; t++) begin
      applyStimulus(2'b11);
      checkOutput($sformatf("rot_grant_%0d", t), grant,
                  (((t - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rot_preempt_%0d", t), preempt,
                  (t > 1 && (t - 1) % 4 == 0) ? 1'b1 : 1'b0);
    end

    // A lone requester keeps the grant with no preemption.
    resetDut();
    for (int t = 1; t <= 20; t++) begin
      applyStimulus(2'b10);
      checkOutput($sformatf("solo_grant_%0d", t), grant, 2'b10);
      checkOutput($sformatf("solo_preempt_%0d", t), preempt, 1'b0);
    end

    // Asynchronous reset mid-cycle clears grant before the next edge.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_grant", grant, 2'b00);
    checkOutput("async_rst_preempt", preempt, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b10);
    checkOutput("after_rst_grant", grant, 2'b10);

    // Pointer advances past last owner through an idle gap.
    resetDut();
    applyStimulus(2'b01);
    checkOutput("seq_grant_01", grant, 2'b01);
    applyStimulus(2'b00);
    checkOutput("seq_grant_00", grant, 2'b00);
    applyStimulus(2'b11);
    checkOutput("seq_grant_10", grant, 2'b10);

    // Owner deasserts exactly when hold expires: deassert wins, no preempt.
    resetDut();
    for (int t = 1; t <= 4; t++) applyStimulus(2'b11);
    checkOutput("expiry_pre_grant", grant, 2'b01);
    applyStimulus(2'b10);
    checkOutput("expiry_deassert_grant", grant, 2'b10);
    checkOutput("expiry_deassert_preempt", preempt, 1'b0);
    applyStimulus(2'b00);
    checkOutput("release_all_grant", grant, 2'b00);
    checkOutput("release_all_preempt", preempt, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
